// File: rtl/loop_sweep_ctrl.sv
// Sweep sequencer for combinational-loop characterisation: applies every input vector,
// classifies the observed nets as settled or oscillating and streams one record per vector.
module loop_sweep_ctrl #(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned OBS_W      = 14,
    parameter int unsigned STABLE_CNT = 100,
    parameter int unsigned SETTLE_MAX = 1000,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OBS_W-1:0] obs,
    input  logic             lut_flag,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IN_W-1:0]  res_vec,
    output logic             res_osc,
    output logic             res_lut,
    output logic             res_mismatch,
    output logic [IN_W:0]    osc_count,
    output logic [IN_W:0]    mis_count
);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StMonitor,
        StReport,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] StableLim = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] WinLim    = CNT_W'(SETTLE_MAX);
    localparam logic [IN_W:0]    CntMax    = {1'b1, {IN_W{1'b0}}};

    state_e             state_q, state_d;
    logic [IN_W-1:0]    vec_q, vec_d;
    logic [IN_W-1:0]    dut_in_q, dut_in_d;
    logic [OBS_W-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [IN_W-1:0]    res_vec_q, res_vec_d;
    logic               res_osc_q, res_osc_d;
    logic               res_lut_q, res_lut_d;
    logic               res_mis_q, res_mis_d;
    logic [IN_W:0]      osc_cnt_q, osc_cnt_d;
    logic [IN_W:0]      mis_cnt_q, mis_cnt_d;

    logic               hit_stable;
    logic               hit_win;
    logic               is_osc;
    logic [CNT_W-1:0]   win_inc;
    logic [CNT_W-1:0]   stable_inc;

    assign win_inc    = win_q + 1'b1;
    assign stable_inc = stable_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        dut_in_d   = dut_in_q;
        prev_d     = prev_q;
        stable_d   = stable_q;
        win_d      = win_q;
        res_vec_d  = res_vec_q;
        res_osc_d  = res_osc_q;
        res_lut_d  = res_lut_q;
        res_mis_d  = res_mis_q;
        osc_cnt_d  = osc_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        hit_stable = 1'b0;
        hit_win    = 1'b0;
        is_osc     = 1'b0;

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        vec_d     = '0;
                        osc_cnt_d = '0;
                        mis_cnt_d = '0;
                        state_d   = StApply;
                    end
                end
                StApply: begin
                    dut_in_d = vec_q;
                    stable_d = '0;
                    win_d    = '0;
                    state_d  = StMonitor;
                end
                StMonitor: begin
                    // The window counts every monitor cycle, the capture cycle included.
                    win_d   = win_inc;
                    hit_win = (win_inc == WinLim);
                    if (win_q == '0) begin
                        prev_d = obs;
                    end else if (obs != prev_q) begin
                        prev_d   = obs;
                        stable_d = '0;
                    end else begin
                        stable_d   = stable_inc;
                        hit_stable = (stable_inc == StableLim);
                    end
                    if (hit_stable || hit_win) begin
                        is_osc    = ~hit_stable;
                        res_vec_d = vec_q;
                        res_osc_d = is_osc;
                        res_lut_d = lut_flag;
                        res_mis_d = is_osc ^ lut_flag;
                        if (is_osc && (osc_cnt_q != CntMax)) begin
                            osc_cnt_d = osc_cnt_q + 1'b1;
                        end
                        if ((is_osc ^ lut_flag) && (mis_cnt_q != CntMax)) begin
                            mis_cnt_d = mis_cnt_q + 1'b1;
                        end
                        state_d = StReport;
                    end
                end
                StReport: begin
                    if (res_ready) begin
                        if (vec_q == {IN_W{1'b1}}) begin
                            state_d = StDone;
                        end else begin
                            vec_d   = vec_q + 1'b1;
                            state_d = StApply;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            vec_q     <= '0;
            dut_in_q  <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
            win_q     <= '0;
            res_vec_q <= '0;
            res_osc_q <= 1'b0;
            res_lut_q <= 1'b0;
            res_mis_q <= 1'b0;
            osc_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            dut_in_q  <= dut_in_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            win_q     <= win_d;
            res_vec_q <= res_vec_d;
            res_osc_q <= res_osc_d;
            res_lut_q <= res_lut_d;
            res_mis_q <= res_mis_d;
            osc_cnt_q <= osc_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign dut_in       = dut_in_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign res_valid    = (state_q == StReport);
    assign res_vec      = res_vec_q;
    assign res_osc      = res_osc_q;
    assign res_lut      = res_lut_q;
    assign res_mismatch = res_mis_q;
    assign osc_count    = osc_cnt_q;
    assign mis_count    = mis_cnt_q;

endmodule

// File: tb/tb_loop_sweep_ctrl.sv
// Bench for loop_sweep_ctrl: a latency-based sweep model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_loop_sweep_ctrl;

    localparam int unsigned IN_W       = 2;
    localparam int unsigned OBS_W      = 4;
    localparam int unsigned STABLE_CNT = 4;
    localparam int unsigned SETTLE_MAX = 16;
    localparam int unsigned CNT_W      = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [IN_W-1:0]  dut_in;
    logic [OBS_W-1:0] obs;
    logic             lut_flag;
    logic             busy;
    logic             done;
    logic             res_valid;
    logic             res_ready;
    logic [IN_W-1:0]  res_vec;
    logic             res_osc;
    logic             res_lut;
    logic             res_mismatch;
    logic [IN_W:0]    osc_count;
    logic [IN_W:0]    mis_count;

    // Scenario knobs that shape the loop-block stand-in.
    logic             tog_en;
    logic             lut_en;
    logic [IN_W-1:0]  osc_vec;
    logic             phase;

    int n_checks;
    int n_fail;
    int n_done;
    logic [IN_W-1:0] rec_q[$];

    loop_sweep_ctrl #(
        .IN_W      (IN_W),
        .OBS_W     (OBS_W),
        .STABLE_CNT(STABLE_CNT),
        .SETTLE_MAX(SETTLE_MAX),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .dut_in      (dut_in),
        .obs         (obs),
        .lut_flag    (lut_flag),
        .busy        (busy),
        .done        (done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_vec     (res_vec),
        .res_osc     (res_osc),
        .res_lut     (res_lut),
        .res_mismatch(res_mismatch),
        .osc_count   (osc_count),
        .mis_count   (mis_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial phase = 1'b0;
    always @(negedge clk) phase <= ~phase;

    assign obs      = (tog_en && (dut_in == osc_vec)) ? (phase ? 4'hA : 4'h5) : 4'h5;
    assign lut_flag = lut_en && (dut_in == 2'd3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic exp_osc(input logic [IN_W-1:0] v);
        return tog_en && (v == osc_vec);
    endfunction

    function automatic logic exp_lut(input logic [IN_W-1:0] v);
        return lut_en && (v == 2'd3);
    endfunction

    // Cycles from APPLY to the record becoming valid.
    function automatic int exp_lat(input logic [IN_W-1:0] v);
        return exp_osc(v) ? SETTLE_MAX + 1 : STABLE_CNT + 2;
    endfunction

    logic            m_busy, m_done, m_valid, m_apply;
    logic [IN_W-1:0] m_vec, m_dut, m_rvec;
    logic            m_rosc, m_rlut;
    logic [IN_W:0]   m_osc_cnt, m_mis_cnt;
    int              m_timer;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_valid <= 0; m_apply <= 0;
            m_vec <= 0; m_dut <= 0; m_rvec <= 0; m_rosc <= 0; m_rlut <= 0;
            m_osc_cnt <= 0; m_mis_cnt <= 0; m_timer <= 0;
        end else begin
            m_done  <= 1'b0;
            m_apply <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1; m_vec <= 0; m_osc_cnt <= 0; m_mis_cnt <= 0;
                    m_timer <= exp_lat(2'd0); m_apply <= 1'b1;
                end
            end else if (abort) begin
                m_busy <= 1'b0; m_valid <= 1'b0; m_timer <= 0;
            end else if (m_done) begin
                m_busy <= 1'b0;
            end else if (m_valid) begin
                if (res_ready) begin
                    m_valid <= 1'b0;
                    if (m_vec == 2'd3) begin
                        m_done <= 1'b1;
                    end else begin
                        m_vec   <= m_vec + 2'd1;
                        m_timer <= exp_lat(m_vec + 2'd1);
                        m_apply <= 1'b1;
                    end
                end
            end else begin
                if (m_apply) m_dut <= m_vec;
                m_timer <= m_timer - 1;
                if (m_timer == 1) begin
                    m_valid   <= 1'b1;
                    m_rvec    <= m_vec;
                    m_rosc    <= exp_osc(m_vec);
                    m_rlut    <= exp_lut(m_vec);
                    m_osc_cnt <= m_osc_cnt + {2'b0, exp_osc(m_vec)};
                    m_mis_cnt <= m_mis_cnt + {2'b0, exp_osc(m_vec) ^ exp_lut(m_vec)};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("res_valid", 32'(res_valid), 32'(m_valid));
            check("dut_in", 32'(dut_in), 32'(m_dut));
            check("osc_count", 32'(osc_count), 32'(m_osc_cnt));
            check("mis_count", 32'(mis_count), 32'(m_mis_cnt));
            check("res_vec", 32'(res_vec), 32'(m_rvec));
            check("res_osc", 32'(res_osc), 32'(m_rosc));
            check("res_lut", 32'(res_lut), 32'(m_rlut));
            check("res_mismatch", 32'(res_mismatch), 32'(m_rosc ^ m_rlut));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready) rec_q.push_back(res_vec);
            if (done) n_done++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_dut(input logic [IN_W-1:0] v, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dut_in == v) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic measure(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (res_valid) break;
        end
    endtask

    task automatic new_sweep();
        rec_q.delete();
        n_done = 0;
    endtask

    int lat;

    initial begin
        n_checks = 0; n_fail = 0; n_done = 0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        tog_en = 1'b0; lut_en = 1'b0; osc_vec = 2'd2;
        #1 rst = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dut_in", 32'(dut_in), 32'd0);
        check("reset_valid", 32'(res_valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_osc_count", 32'(osc_count), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // 1: everything settles, no LUT flags
        new_sweep();
        pulse_start();
        wait_dut(2'd1, "s1_reach_vec1");
        measure(lat);
        check("s1_settle_latency", 32'(lat), 32'd5);
        wait_done("s1_done");
        tick(1);
        check("s1_records", 32'(rec_q.size()), 32'd4);
        check("s1_first_rec", 32'(rec_q[0]), 32'd0);
        check("s1_last_rec", 32'(rec_q[3]), 32'd3);
        check("s1_done_pulses", 32'(n_done), 32'd1);
        check("s1_osc_count", 32'(osc_count), 32'd0);
        check("s1_mis_count", 32'(mis_count), 32'd0);
        check("s1_idle", 32'(busy), 32'd0);
        check("s1_dut_in_held", 32'(dut_in), 32'd3);

        // 2: vector 2 oscillates
        new_sweep();
        tog_en = 1'b1; osc_vec = 2'd2;
        pulse_start();
        wait_dut(2'd2, "s2_reach_vec2");
        measure(lat);
        check("s2_osc_latency", 32'(lat), 32'd16);
        check("s2_res_osc", 32'(res_osc), 32'd1);
        wait_done("s2_done");
        tick(1);
        check("s2_osc_count", 32'(osc_count), 32'd1);
        check("s2_mis_count", 32'(mis_count), 32'd1);
        tog_en = 1'b0;

        // 3: LUT predicts oscillation for vector 3 only
        new_sweep();
        lut_en = 1'b1;
        pulse_start();
        wait_done("s3_done");
        tick(1);
        check("s3_res_vec", 32'(res_vec), 32'd3);
        check("s3_res_lut", 32'(res_lut), 32'd1);
        check("s3_res_mismatch", 32'(res_mismatch), 32'd1);
        check("s3_mis_count", 32'(mis_count), 32'd1);
        check("s3_osc_count", 32'(osc_count), 32'd0);
        lut_en = 1'b0;

        // 4: consumer stalls on the vector 1 record
        new_sweep();
        pulse_start();
        wait_dut(2'd1, "s4_reach_vec1");
        tick(1);
        res_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            check("s4_stall_valid", 32'(res_valid), 32'd1);
            check("s4_stall_vec", 32'(res_vec), 32'd1);
            check("s4_stall_dut_in", 32'(dut_in), 32'd1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        wait_done("s4_done");
        tick(1);
        check("s4_records", 32'(rec_q.size()), 32'd4);

        // 5: reset in the middle of monitoring vector 2
        new_sweep();
        tog_en = 1'b1; osc_vec = 2'd1;
        pulse_start();
        wait_dut(2'd2, "s5_reach_vec2");
        tick(3);
        check("s5_osc_before_rst", 32'(osc_count), 32'd1);
        rst = 1'b1;
        #1;
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_dut_in", 32'(dut_in), 32'd0);
        check("s5_rst_osc_count", 32'(osc_count), 32'd0);
        tick(1);
        rst = 1'b0;
        tog_en = 1'b0;
        tick(1);
        new_sweep();
        pulse_start();
        wait_done("s5_done");
        tick(1);
        check("s5_records", 32'(rec_q.size()), 32'd4);
        check("s5_first_rec", 32'(rec_q[0]), 32'd0);

        // 6: start ignored while busy, then abort during vector 1
        new_sweep();
        pulse_start();
        tick(3);
        pulse_start();
        wait_dut(2'd1, "s6_reach_vec1");
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("s6_abort_idle", 32'(busy), 32'd0);
        check("s6_abort_valid", 32'(res_valid), 32'd0);
        tick(40);
        check("s6_records", 32'(rec_q.size()), 32'd1);
        check("s6_no_done", 32'(n_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
